// File: rtl/useq_pkg.sv
// Shared types for the microsequencer next-address control stage:
// Am2910-style opcodes, 2909 source selects and the registered microword control fields.
package useq_pkg;

    localparam int STACK_DEPTH = 4;

    typedef enum logic [3:0] {
        OP_JZ   = 4'd0,
        OP_CJS  = 4'd1,
        OP_JMAP = 4'd2,
        OP_CJP  = 4'd3,
        OP_PUSH = 4'd4,
        OP_JSRP = 4'd5,
        OP_CJV  = 4'd6,
        OP_JRP  = 4'd7,
        OP_RFCT = 4'd8,
        OP_RPCT = 4'd9,
        OP_CRTN = 4'd10,
        OP_CJPP = 4'd11,
        OP_LDCT = 4'd12,
        OP_LOOP = 4'd13,
        OP_CONT = 4'd14,
        OP_TWB  = 4'd15
    } opcode_e;

    localparam logic [1:0] SRC_PC    = 2'b00;
    localparam logic [1:0] SRC_AR    = 2'b01;
    localparam logic [1:0] SRC_STACK = 2'b10;
    localparam logic [1:0] SRC_D     = 2'b11;

    typedef struct packed {
        opcode_e op;
        logic    ccen;
        logic    cpol;
        logic    ar_ld;
    } uw_ctl_t;

endpackage

// File: rtl/useq_loop_counter.sv
// Loop counter for the next-address stage: parallel load, decrement that
// stops at zero, and a zero flag for the counted-loop opcodes.
module useq_loop_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             cnt_zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign cnt_zero = (count == '0);

endmodule

// File: rtl/useq_next_addr_ctl.sv
// Next-address control stage feeding cascaded Am2909 slices: registers the
// microword next-address fields and decodes them into sequencer controls each cycle.
module useq_next_addr_ctl
    import useq_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 8,
    parameter int NCOND  = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [3:0]               uw_op,
    input  logic                     uw_ccen,
    input  logic [$clog2(NCOND)-1:0] uw_csel,
    input  logic                     uw_cpol,
    input  logic                     uw_ar_ld,
    input  logic [ADDR_W-1:0]        uw_branch,
    input  logic [NCOND-1:0]         cond_in,
    input  logic [ADDR_W-1:0]        map_addr,
    input  logic [ADDR_W-1:0]        vec_addr,
    output logic [1:0]               seq_s,
    output logic                     seq_fe,
    output logic                     seq_pup,
    output logic                     seq_zero,
    output logic                     seq_re,
    output logic [ADDR_W-1:0]        seq_din,
    output logic [ADDR_W-1:0]        seq_rin,
    output logic                     cnt_zero,
    output logic                     stack_err
);

    localparam int         CSEL_W    = $clog2(NCOND);
    localparam logic [2:0] DEPTH_MAX = 3'(STACK_DEPTH);

    uw_ctl_t           pl;
    logic [CSEL_W-1:0] pl_csel;
    logic [ADDR_W-1:0] pl_branch;
    logic [2:0]        depth;
    logic              pass;
    logic              cnt_load;
    logic              cnt_dec;
    logic              do_push;
    logic              do_pop;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pl        <= '{op: OP_JZ, ccen: 1'b0, cpol: 1'b0, ar_ld: 1'b0};
            pl_csel   <= '0;
            pl_branch <= '0;
        end else begin
            pl        <= '{op: opcode_e'(uw_op), ccen: uw_ccen, cpol: uw_cpol, ar_ld: uw_ar_ld};
            pl_csel   <= uw_csel;
            pl_branch <= uw_branch;
        end
    end

    assign pass = pl.ccen ? (cond_in[pl_csel] ^ pl.cpol) : 1'b1;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        seq_s    = SRC_PC;
        seq_fe   = 1'b1;
        seq_pup  = 1'b0;
        seq_zero = 1'b1;
        seq_din  = pl_branch;
        seq_rin  = pl_branch;
        seq_re   = ~pl.ar_ld;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (pl.op)
            OP_JZ:   seq_zero = 1'b0;
            OP_CJS:  if (pass) begin seq_s = SRC_D; seq_fe = 1'b0; seq_pup = 1'b1; end
            OP_JMAP: begin seq_s = SRC_D; seq_din = map_addr; end
            OP_CJP:  if (pass) seq_s = SRC_D;
            OP_PUSH: begin seq_fe = 1'b0; seq_pup = 1'b1; cnt_load = pass; end
            OP_JSRP: begin seq_s = pass ? SRC_D : SRC_AR; seq_fe = 1'b0; seq_pup = 1'b1; end
            OP_CJV:  if (pass) begin seq_s = SRC_D; seq_din = vec_addr; end
            OP_JRP:  seq_s = pass ? SRC_D : SRC_AR;
            OP_RFCT: if (!cnt_zero) begin seq_s = SRC_STACK; cnt_dec = 1'b1; end
                     else seq_fe = 1'b0;
            OP_RPCT: if (!cnt_zero) begin seq_s = SRC_D; cnt_dec = 1'b1; end
            OP_CRTN: if (pass) begin seq_s = SRC_STACK; seq_fe = 1'b0; end
            OP_CJPP: if (pass) begin seq_s = SRC_D; seq_fe = 1'b0; end
            OP_LDCT: cnt_load = 1'b1;
            OP_LOOP: if (pass) seq_fe = 1'b0;
                     else seq_s = SRC_STACK;
            OP_CONT: ;
            OP_TWB: begin
                // Two-way exit: condition wins over counter exhaustion.
                if (pass) begin
                    seq_fe = 1'b0;
                end else if (!cnt_zero) begin
                    seq_s   = SRC_STACK;
                    cnt_dec = 1'b1;
                end else begin
                    seq_s  = SRC_D;
                    seq_fe = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign do_push = !seq_fe && seq_pup;
    assign do_pop  = !seq_fe && !seq_pup;

    // Depth saturates at the file limits; the slices themselves wrap regardless.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            depth     <= '0;
            stack_err <= 1'b0;
        end else if (do_push) begin
            if (depth == DEPTH_MAX) stack_err <= 1'b1;
            else                    depth     <= depth + 3'd1;
        end else if (do_pop) begin
            if (depth == 3'd0) stack_err <= 1'b1;
            else               depth     <= depth - 3'd1;
        end
    end

    useq_loop_counter #(.CNT_W(CNT_W)) u_loop_counter (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (pl_branch[CNT_W-1:0]),
        .cnt_zero (cnt_zero)
    );

endmodule

// File: tb/tb_useq_next_addr_ctl.sv
// Bench for useq_next_addr_ctl: directed scenarios then random microwords,
// each checked against a table-driven model of the opcode actions.
module tb_useq_next_addr_ctl;

    localparam int ADDR_W = 12;
    localparam int CNT_W  = 8;
    localparam int NCOND  = 8;

    // Source encodings on {S1,S0} and model action codes.
    localparam int PC = 0, AR = 1, STK = 2, D = 3;
    localparam int NONE = 0, PUSH = 1, POP = 2, LOAD = 1, DEC = 2;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [3:0]        uw_op = '0;
    logic              uw_ccen = 1'b0;
    logic [2:0]        uw_csel = '0;
    logic              uw_cpol = 1'b0;
    logic              uw_ar_ld = 1'b0;
    logic [ADDR_W-1:0] uw_branch = '0;
    logic [NCOND-1:0]  cond_in = '0;
    logic [ADDR_W-1:0] map_addr = '0;
    logic [ADDR_W-1:0] vec_addr = '0;
    logic [1:0]        seq_s;
    logic              seq_fe, seq_pup, seq_zero, seq_re;
    logic [ADDR_W-1:0] seq_din, seq_rin;
    logic              cnt_zero, stack_err;

    useq_next_addr_ctl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .NCOND(NCOND)) dut (
        .clock(clock), .reset_n(reset_n), .uw_op(uw_op), .uw_ccen(uw_ccen),
        .uw_csel(uw_csel), .uw_cpol(uw_cpol), .uw_ar_ld(uw_ar_ld), .uw_branch(uw_branch),
        .cond_in(cond_in), .map_addr(map_addr), .vec_addr(vec_addr),
        .seq_s(seq_s), .seq_fe(seq_fe), .seq_pup(seq_pup), .seq_zero(seq_zero),
        .seq_re(seq_re), .seq_din(seq_din), .seq_rin(seq_rin),
        .cnt_zero(cnt_zero), .stack_err(stack_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int src;
        int stk;
        int cnt;
    } act_t;

    act_t on_true[16];
    act_t on_false[16];
    act_t twb_exhausted;

    int m_cnt, m_depth;
    bit m_err;
    int vectors, miscompares;

    function automatic act_t mk(input int src, input int stk, input int cnt);
        act_t a;
        a.src = src; a.stk = stk; a.cnt = cnt;
        return a;
    endfunction

    // Test column is the condition, except RFCT/RPCT where it is "counter non-zero".
    task automatic build_tables();
        on_true[0]  = mk(PC, NONE, NONE);  on_false[0]  = mk(PC, NONE, NONE);
        on_true[1]  = mk(D, PUSH, NONE);   on_false[1]  = mk(PC, NONE, NONE);
        on_true[2]  = mk(D, NONE, NONE);   on_false[2]  = mk(D, NONE, NONE);
        on_true[3]  = mk(D, NONE, NONE);   on_false[3]  = mk(PC, NONE, NONE);
        on_true[4]  = mk(PC, PUSH, LOAD);  on_false[4]  = mk(PC, PUSH, NONE);
        on_true[5]  = mk(D, PUSH, NONE);   on_false[5]  = mk(AR, PUSH, NONE);
        on_true[6]  = mk(D, NONE, NONE);   on_false[6]  = mk(PC, NONE, NONE);
        on_true[7]  = mk(D, NONE, NONE);   on_false[7]  = mk(AR, NONE, NONE);
        on_true[8]  = mk(STK, NONE, DEC);  on_false[8]  = mk(PC, POP, NONE);
        on_true[9]  = mk(D, NONE, DEC);    on_false[9]  = mk(PC, NONE, NONE);
        on_true[10] = mk(STK, POP, NONE);  on_false[10] = mk(PC, NONE, NONE);
        on_true[11] = mk(D, POP, NONE);    on_false[11] = mk(PC, NONE, NONE);
        on_true[12] = mk(PC, NONE, LOAD);  on_false[12] = mk(PC, NONE, LOAD);
        on_true[13] = mk(PC, POP, NONE);   on_false[13] = mk(STK, NONE, NONE);
        on_true[14] = mk(PC, NONE, NONE);  on_false[14] = mk(PC, NONE, NONE);
        on_true[15] = mk(PC, POP, NONE);   on_false[15] = mk(STK, NONE, DEC);
        twb_exhausted = mk(D, POP, NONE);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".s"},        32'(seq_s), 0);
        check({tag, ".fe"},       32'(seq_fe), 1);
        check({tag, ".pup"},      32'(seq_pup), 0);
        check({tag, ".zero"},     32'(seq_zero), 0);
        check({tag, ".re"},       32'(seq_re), 1);
        check({tag, ".din"},      32'(seq_din), 0);
        check({tag, ".rin"},      32'(seq_rin), 0);
        check({tag, ".cnt_zero"}, 32'(cnt_zero), 1);
        check({tag, ".err"},      32'(stack_err), 0);
    endtask

    // Asserts reset away from any clock edge, checks, then releases on a falling edge.
    task automatic pulse_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset({tag, "_during"});
        uw_op = '0; uw_ccen = 1'b0; uw_csel = '0; uw_cpol = 1'b0;
        uw_ar_ld = 1'b0; uw_branch = '0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_reset({tag, "_after"});
        m_cnt = 0; m_depth = 0; m_err = 1'b0;
    endtask

    task automatic step(input int op, input bit ccen, input int csel, input bit cpol,
                        input bit ar, input int br, input logic [7:0] cond,
                        input int mp = 0, input int vc = 0);
        act_t  a;
        bit    pass;
        int    exp_din;
        string t;
        logic [ADDR_W-1:0] br_v;
        @(negedge clock);
        uw_op = 4'(op); uw_ccen = ccen; uw_csel = 3'(csel); uw_cpol = cpol;
        uw_ar_ld = ar; uw_branch = 12'(br);
        @(posedge clock);
        #1;
        cond_in = cond; map_addr = 12'(mp); vec_addr = 12'(vc);
        #1;
        br_v = 12'(br);
        pass = ccen ? (cond[csel] ^ cpol) : 1'b1;
        if (op == 15)
            a = pass ? on_true[15] : (m_cnt != 0 ? on_false[15] : twb_exhausted);
        else if (op == 8 || op == 9)
            a = (m_cnt != 0) ? on_true[op] : on_false[op];
        else
            a = pass ? on_true[op] : on_false[op];
        if (op == 2)              exp_din = mp & 12'hfff;
        else if (op == 6 && pass) exp_din = vc & 12'hfff;
        else                      exp_din = int'(br_v);
        t = $sformatf("op%0d", op);
        check({t, ".s"},        32'(seq_s), 32'(a.src));
        check({t, ".fe"},       32'(seq_fe), (a.stk == NONE) ? 1 : 0);
        check({t, ".pup"},      32'(seq_pup), (a.stk == PUSH) ? 1 : 0);
        check({t, ".zero"},     32'(seq_zero), (op == 0) ? 0 : 1);
        check({t, ".din"},      32'(seq_din), 32'(exp_din));
        check({t, ".rin"},      32'(seq_rin), 32'(br_v));
        check({t, ".re"},       32'(seq_re), ar ? 0 : 1);
        check({t, ".cnt_zero"}, 32'(cnt_zero), (m_cnt == 0) ? 1 : 0);
        check({t, ".err"},      32'(stack_err), 32'(m_err));
        // State effects land on the next rising edge.
        if (a.stk == PUSH) begin
            if (m_depth == 4) m_err = 1'b1; else m_depth++;
        end else if (a.stk == POP) begin
            if (m_depth == 0) m_err = 1'b1; else m_depth--;
        end
        if (a.cnt == LOAD)                  m_cnt = br & 8'hff;
        else if (a.cnt == DEC && m_cnt > 0) m_cnt--;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_cnt = 0; m_depth = 0; m_err = 1'b0;
        build_tables();

        #3;
        check_reset("por");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_reset("por_after");

        // Counted repeat: three D cycles then fall through to PC.
        step(12, 0, 0, 0, 0, 3, 8'h00);
        repeat (4) step(9, 0, 0, 0, 0, 'h120, 8'h00);
        step(14, 0, 0, 0, 0, 0, 8'h00);

        // Conditional call taken, then not taken with inverted polarity.
        step(1, 1, 2, 0, 0, 'h045, 8'h04);
        step(1, 1, 2, 1, 0, 'h045, 8'h04);
        // Return from the one pushed frame.
        step(10, 0, 0, 0, 1, 'h3a5, 8'h00);
        step(14, 0, 0, 0, 0, 0, 8'h00);

        // Overflow: fifth push sets the sticky error.
        repeat (5) step(4, 0, 0, 0, 0, 0, 8'h00);
        repeat (3) step(14, 0, 0, 0, 0, 'h7ff, 8'h00);

        // Jump-map and vector with distinct address buses.
        step(2, 0, 0, 0, 0, 'h111, 8'h00, 'h2a2, 'h3b3);
        step(6, 1, 5, 0, 0, 'h111, 8'h20, 'h2a2, 'h3b3);
        step(6, 1, 5, 0, 0, 'h111, 8'h00, 'h2a2, 'h3b3);

        // Asynchronous reset in the middle of a counted loop.
        step(12, 0, 0, 0, 0, 5, 8'h00);
        repeat (2) step(9, 0, 0, 0, 0, 'h0f0, 8'h00);
        pulse_reset("rst_mid_loop");
        step(0, 0, 0, 0, 0, 'h0ab, 8'h00);

        // Two-way branch: counter exhausts, then a condition pass exits early.
        step(4, 0, 0, 0, 0, 2, 8'h00);
        repeat (3) step(15, 1, 0, 0, 0, 'h055, 8'h00);
        step(4, 0, 0, 0, 0, 2, 8'h00);
        step(15, 1, 0, 0, 0, 'h055, 8'h01);
        step(14, 0, 0, 0, 0, 0, 8'h00);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) pulse_reset("rst_random");
            step($urandom_range(0, 15), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
                 1'($urandom), int'($urandom_range(0, 4095)), 8'($urandom),
                 int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/useq_next_addr_ctl.md
Name: useq_next_addr_ctl

Overview:
- Next-address control stage directly upstream of the Am2909 sequencer slices.
- Registers the next-address fields of the microword fetched from the control store (pipeline register).
- Evaluates the selected branch condition and an internal loop counter, and drives the sequencer controls (S1/S0, FE, PUP, ZERO, RE) and the D bus each cycle.
- Implements the 16-op Am2910-style instruction set on top of cascaded 2909 slices; tracks stack depth to flag over/underflow.

Parameters:
- ADDR_W, 12: microaddress width (three cascaded 4-bit slices).
- CNT_W, 8: loop counter width, CNT_W <= ADDR_W.
- NCOND, 8: number of condition inputs.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- uw_op  in  4  next-address opcode field from control store.
- uw_ccen  in  1  1 = condition test enabled; 0 = forced pass.
- uw_csel  in  $clog2(NCOND)  condition select.
- uw_cpol  in  1  1 = invert selected condition.
- uw_ar_ld  in  1  load sequencer AR from branch field.
- uw_branch  in  ADDR_W  branch/count field.
- cond_in  in  NCOND  live status conditions.
- map_addr  in  ADDR_W  opcode mapping ROM address.
- vec_addr  in  ADDR_W  interrupt vector address.
- seq_s  out  2  {S1,S0} to all slices: 00 PC, 01 AR, 10 STACK, 11 D.
- seq_fe  out  1  file enable, active low.
- seq_pup  out  1  1 push / 0 pop when seq_fe = 0.
- seq_zero  out  1  active-low force Y = 0.
- seq_re  out  1  active-low AR load.
- seq_din  out  ADDR_W  D bus to slices.
- seq_rin  out  ADDR_W  AR input bus.
- cnt_zero  out  1  loop counter == 0.
- stack_err  out  1  sticky stack overflow/underflow.

Behaviour:
- Pipeline register latches all uw_* fields every rising clock edge; no stall.
- Sequencer outputs are combinational from pipeline register, cond_in, counter, and depth. Zero extra latency.
- pass = uw_ccen ? (cond_in[csel] ^ cpol) : 1.
- Defaults: seq_zero = 1, seq_fe = 1, seq_pup = 0, seq_din = branch, seq_rin = branch, seq_re = ~ar_ld. Sequencer CIN is tied to 1 externally.
- Opcode encodings and actions ("push" = fe 0/pup 1; "pop" = fe 0/pup 0):
  - 0 JZ: seq_zero = 0, s = PC.
  - 1 CJS: pass → D + push; fail → PC.
  - 2 JMAP: D with din = map_addr.
  - 3 CJP: pass → D; fail → PC.
  - 4 PUSH: PC + push; if pass, load counter.
  - 5 JSRP: push; pass → D, fail → AR.
  - 6 CJV: pass → D with din = vec_addr; fail → PC.
  - 7 JRP: pass → D; fail → AR.
  - 8 RFCT: cnt != 0 → STACK, decrement; cnt == 0 → PC + pop.
  - 9 RPCT: cnt != 0 → D, decrement; cnt == 0 → PC.
  - 10 CRTN: pass → STACK + pop; fail → PC.
  - 11 CJPP: pass → D + pop; fail → PC.
  - 12 LDCT: PC, load counter.
  - 13 LOOP: pass → PC + pop; fail → STACK.
  - 14 CONT: PC.
  - 15 TWB: pass → PC + pop; fail & cnt != 0 → STACK, decrement; fail & cnt == 0 → D + pop.
- Counter:
  - Load = uw_branch[CNT_W-1:0] at clock edge.
  - Decrement only when != 0; never wraps.
  - Load and decrement are exclusive by opcode.
- Depth tracker (0..4, mirroring the 4-deep 2909 file):
  - Push increments, pop decrements.
  - Push at depth 4 or pop at depth 0 sets stack_err (sticky) and leaves depth saturated. Stack traffic is still driven, since the slices wrap.
- ar_ld is independent of opcode. AR load and stack ops may coincide.
- Reset (asynchronous, any time including mid-loop):
  - Pipeline op = JZ, all other fields 0, counter = 0, depth = 0, stack_err = 0.
  - Outputs during and immediately after reset: seq_zero = 0, seq_s = 00, seq_fe = 1, seq_pup = 0, seq_re = 1, seq_din = 0, seq_rin = 0, cnt_zero = 1, stack_err = 0.
  - First microaddress after reset is 0.

Decomposition:
- Shared package useq_pkg: opcode enum (the 16 codes above), sequencer source constants (SRC_PC/AR/STACK/D), pipeline-field struct, stack depth constant 4.
- One natural sub-module, useq_loop_counter: load/decrement/zero flag. The opcode decode stays in the top module.

Test Plan:
- Reset pulse mid-RPCT loop with cnt = 5 → asynchronously seq_zero = 0, cnt_zero = 1, stack_err = 0; next cycle op = JZ.
- LDCT branch = 3, then RPCT branch = 0x120 four cycles → seq_s = 11 and din = 0x120 for 3 cycles (cnt 3 → 0), then seq_s = 00; cnt_zero = 1.
- CJS branch = 0x045 with cond_in[2] = 1, csel = 2, cpol = 0 → seq_s = 11, fe = 0, pup = 1. Repeat with cpol = 1 → seq_s = 00, fe = 1.
- CRTN pass after one CJS → seq_s = 10, fe = 0, pup = 0; depth returns to 0; stack_err stays 0.
- Five consecutive PUSH ops → stack_err rises on the fifth edge and stays 1 through later CONT ops until reset.
- TWB with cnt = 2 and cond failing → STACK for 2 cycles, then D + pop. With cond passing at cycle 1 → PC + pop.
